// File: rtl/dsp_equation_scheduler.sv
// Queues DSP equation commands and sequences them through the datapath registers.
// Each command gets a start pulse, then waits for done, abort or timeout, and its result is held until accepted.
//
// state     | meaning
// S_IDLE    | nothing running; leave when the command FIFO holds an entry
// S_LOAD    | pop head, register equation number and operands
// S_START   | one-cycle start strobe on dsp_input0_reg[31]
// S_WAIT    | count cycles until abort, done or timeout
// S_CAPTURE | hold result until result_ready
module dsp_equation_scheduler #(
  parameter int dw      = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_eq,
  input  logic [dw-1:0] cmd_arg0,
  input  logic [dw-1:0] cmd_arg1,
  output logic [dw-1:0] dsp_input0_reg,
  output logic [dw-1:0] dsp_input1_reg,
  output logic [dw-1:0] dsp_input2_reg,
  input  logic          done,
  input  logic [dw-1:0] dsp_output0_reg,
  input  logic          abort,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [dw-1:0] result_data,
  output logic [7:0]    result_eq,
  output logic [1:0]    result_status,
  output logic          busy,
  output logic          irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE} state_t;

  state_t state_q, state_d;

  logic [7:0]    fifo_eq [DEPTH];
  logic [dw-1:0] fifo_a0 [DEPTH];
  logic [dw-1:0] fifo_a1 [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  logic [7:0]    eq_q, head_eq;
  logic          start_q;
  logic [TW-1:0] timer;
  logic          load_en, cap_en, accept, eq_ok;
  logic [1:0]    cap_status;
  logic [dw-1:0] cap_data;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head_eq   = fifo_eq[rd_ptr];
  assign eq_ok     = (head_eq >= 8'd1) && (head_eq <= 8'd3);
  assign busy      = (state_q != S_IDLE) || !empty;

  always_ff @(posedge wb_clk) begin
    if (push) begin
      fifo_eq[wr_ptr] <= cmd_eq;
      fifo_a0[wr_ptr] <= cmd_arg0;
      fifo_a1[wr_ptr] <= cmd_arg1;
    end
  end

  // Pop is only issued from LOAD, which is only entered with a non-empty FIFO.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    load_en    = 1'b0;
    cap_en     = 1'b0;
    cap_status = 2'b00;
    cap_data   = '0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_LOAD;
      S_LOAD: begin
        pop     = 1'b1;
        load_en = 1'b1;
        if (eq_ok) begin
          state_d = S_START;
        end else begin
          state_d    = S_CAPTURE;
          cap_en     = 1'b1;
          cap_status = 2'b10;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (abort) begin
          state_d    = S_CAPTURE;
          cap_en     = 1'b1;
          cap_status = 2'b11;
        end else if (done) begin
          state_d  = S_CAPTURE;
          cap_en   = 1'b1;
          cap_data = dsp_output0_reg;
        end else if (timer == TMAX) begin
          state_d    = S_CAPTURE;
          cap_en     = 1'b1;
          cap_status = 2'b01;
        end
      end
      S_CAPTURE: begin
        if (result_ready) begin
          accept  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      eq_q           <= '0;
      start_q        <= 1'b0;
      dsp_input1_reg <= '0;
      dsp_input2_reg <= '0;
      timer          <= '0;
      result_valid   <= 1'b0;
      result_data    <= '0;
      result_eq      <= '0;
      result_status  <= 2'b00;
      irq            <= 1'b0;
    end else begin
      start_q <= load_en && eq_ok;
      irq     <= accept;
      if (load_en) begin
        eq_q           <= head_eq;
        dsp_input1_reg <= fifo_a0[rd_ptr];
        dsp_input2_reg <= fifo_a1[rd_ptr];
      end else if (accept) begin
        eq_q <= '0;
      end
      if (state_q == S_START)     timer <= '0;
      else if (state_q == S_WAIT) timer <= timer + 1'b1;
      // A bad equation is captured straight from LOAD, before eq_q holds it.
      if (cap_en) begin
        result_valid  <= 1'b1;
        result_data   <= cap_data;
        result_status <= cap_status;
        result_eq     <= load_en ? head_eq : eq_q;
      end else if (accept) begin
        result_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    dsp_input0_reg      = '0;
    dsp_input0_reg[7:0] = eq_q;
    dsp_input0_reg[31]  = start_q;
  end

endmodule

// File: doc/dsp_equation_scheduler.md
DSP_EQUATION_SCHEDULER -- requirements
Module: dsp_equation_scheduler

Interface
REQ-001 Parameters (name, default, meaning): dw, 32, datapath word width; DEPTH, 4, command FIFO entries (power of 2, >=2); TIMEOUT, 1024, max WAIT cycles before forced completion.
REQ-002 wb_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 wb_rst  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  FIFO can accept; equals !full.
REQ-006 cmd_eq  in  8  equation number (1=SUM, 2=MULTIPLY, 3=DTREE).
REQ-007 cmd_arg0, cmd_arg1  in  dw each  operands for dsp_input1_reg / dsp_input2_reg.
REQ-008 dsp_input0_reg  out  dw  [7:0] equation number, [31] start, other bits 0.
REQ-009 dsp_input1_reg, dsp_input2_reg  out  dw each  registered operands.
REQ-010 done  in  1  equation-complete from datapath.
REQ-011 dsp_output0_reg  in  dw  datapath result.
REQ-012 abort  in  1  abandon running equation.
REQ-013 result_valid  out  1; result_ready  in  1  result handshake.
REQ-014 result_data  out  dw; result_eq  out  8; result_status  out  2 (00 ok, 01 timeout, 10 bad equation, 11 aborted).
REQ-015 busy  out  1  FSM not IDLE or FIFO non-empty; irq  out  1  one-cycle pulse per completed result acceptance.

Function
REQ-016 Command FIFO, DEPTH entries of {eq, arg0, arg1}; push when cmd_valid && cmd_ready; pop only in LOAD; pointers wrap modulo DEPTH; full/empty from (DEPTH+1)-state count.
REQ-017 cmd_valid while full SHALL be ignored, FIFO contents unchanged.
REQ-018 FSM states: IDLE, LOAD, START, WAIT, CAPTURE.
REQ-019 IDLE: FIFO non-empty -> LOAD next cycle; else stay; dsp_input0_reg[7:0]=0.
REQ-020 LOAD: pop head; register eq into dsp_input0_reg[7:0], args into dsp_input1/2_reg, start=0; valid eq (1..3) -> START; else -> CAPTURE with status 10, result_data 0.
REQ-021 START: dsp_input0_reg[31]=1 for exactly one cycle; timer cleared to 0; -> WAIT.
REQ-022 WAIT: timer increments each cycle; priority abort > done > timeout.
REQ-023 WAIT abort=1 -> CAPTURE, status 11, result_data 0.
REQ-024 WAIT done=1 -> CAPTURE, status 00, result_data = dsp_output0_reg sampled that cycle.
REQ-025 WAIT timer==TIMEOUT-1 without done -> CAPTURE, status 01, result_data 0.
REQ-026 CAPTURE: result_valid=1, result_eq/status/data held stable until result_ready=1; accept cycle pulses irq next cycle, clears dsp_input0_reg[7:0] to 0, -> IDLE.
REQ-027 Latency: command pushed into empty FIFO with FSM IDLE -> start pulse 3 cycles later (IDLE, LOAD, START).
REQ-028 done or abort outside WAIT SHALL be ignored.
REQ-029 Pushes permitted in every state, including same cycle as LOAD pop; count then unchanged.
REQ-030 Equation number and operands SHALL stay constant from LOAD through CAPTURE.

Reset
REQ-031 wb_rst=1 asynchronously forces: FSM IDLE, FIFO empty, pointers 0, timer 0, all dsp_input*_reg 0, result_valid 0, result_data 0, result_eq 0, result_status 00, irq 0, busy 0, cmd_ready 1.
REQ-032 Reset mid-WAIT discards running equation and queued commands; no result or irq produced.

Verification
REQ-033 Push {eq=1, arg0=5, arg1=7}, done=1 with dsp_output0_reg=12 five cycles after start -> result_valid, result_data=12, result_eq=1, status 00, one irq pulse after result_ready.
REQ-034 Push 5 commands back-to-back with no progress -> first 4 accepted, cmd_ready=0 on 5th; all 4 execute in FIFO order.
REQ-035 Push eq=9 -> no start pulse, result status 10, result_data 0, FSM returns IDLE.
REQ-036 TIMEOUT=16, never assert done -> status 01 exactly 16 cycles after START; abort and done same WAIT cycle -> status 11.
REQ-037 Hold result_ready=0 for 10 cycles -> result outputs stable, no irq, next command not started until acceptance.
REQ-038 Assert wb_rst during WAIT with 2 queued commands -> outputs at reset values immediately, no result after release.
